// File: rtl/fir_frame_buffer.sv
// fir_frame_buffer: ping-pong collector of serial FIR samples into N-word frames for a block consumer.
// Define FIR_FRAME_BITREV_EN to store each frame in bit-reversed slot order (radix-2 DIT FFT input).
module fir_frame_buffer #(
    parameter int DW    = 16,
    parameter int N     = 16,
    parameter int LOG2N = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [DW-1:0]   in_data,
    output logic            frame_valid,
    input  logic            frame_ready,
    output logic [N*DW-1:0] frame_data,
    output logic            overflow,
    input  logic            ovf_clr
);
    logic [DW-1:0]    mem [2][N];
    logic             wbank, rbank;
    logic [LOG2N-1:0] wptr, waddr;
    logic [1:0]       full, set, clr;
    logic             accept, drop, take, last;
    assign accept = in_valid && !full[wbank];
    assign drop = in_valid && full[wbank];
    assign take = frame_valid && frame_ready;
    assign last = wptr == LOG2N'(N - 1);
    assign set = (accept && last) ? (wbank ? 2'b10 : 2'b01) : 2'b00;
    assign clr = take ? (rbank ? 2'b10 : 2'b01) : 2'b00;
    assign frame_valid = full[rbank];
`ifdef FIR_FRAME_BITREV_EN
    always_comb begin
        waddr = '0;
        for (int i = 0; i < LOG2N; i++) waddr[i] = wptr[LOG2N-1-i];
    end
`else
    assign waddr = wptr;
`endif
    always_comb begin
        frame_data = '0;
        for (int k = 0; k < N; k++) frame_data[k*DW +: DW] = mem[rbank][k];
    end
    // the filling bank is never the presented full bank, so set and clr never collide
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wbank    <= 1'b0;
            rbank    <= 1'b0;
            wptr     <= '0;
            full     <= 2'b00;
            overflow <= 1'b0;
            for (int b = 0; b < 2; b++)
                for (int k = 0; k < N; k++) mem[b][k] <= '0;
        end else begin
            if (accept) begin
                mem[wbank][waddr] <= in_data;
                wptr <= wptr + LOG2N'(1);
                if (last) wbank <= !wbank;
            end
            if (take) rbank <= !rbank;
            full     <= (full & ~clr) | set;
            overflow <= drop | (overflow & !ovf_clr);
        end
    end
endmodule

// File: tb/tb_fir_frame_buffer.sv
// tb_fir_frame_buffer: randomized scoreboard bench; a frame-level model predicts frames, drops and overflow.
module tb_fir_frame_buffer;
    localparam int DW = 16, N = 16, LOG2N = 4;
    logic            clk, rst, in_valid, frame_valid, frame_ready, overflow, ovf_clr;
    logic [DW-1:0]   in_data;
    logic [N*DW-1:0] frame_data, f;
    int tests = 0, failed = 0, hs = 0, held = 0, h0;
    logic m_ovf = 0;
    logic [DW-1:0]   part[$];
    logic [N*DW-1:0] expq[$];

    fir_frame_buffer #(.DW(DW), .N(N), .LOG2N(LOG2N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_data(frame_data),
        .overflow(overflow), .ovf_clr(ovf_clr)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic int slot(int i);
`ifdef FIR_FRAME_BITREV_EN
        int r = 0;
        for (int b = 0; b < LOG2N; b++) r |= ((i >> b) & 1) << (LOG2N - 1 - b);
        return r;
`else
        return i;
`endif
    endfunction

    task automatic chk(input string nm, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic r, input logic c);
        in_valid = v; in_data = d; frame_ready = r; ovf_clr = c;
        @(posedge clk);
        #1;
    endtask

    // model: up to two held frames plus one partial frame; a full pair drops input
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            held = 0; part.delete(); expq.delete(); m_ovf = 0;
        end else begin
            automatic int hb = held;
            automatic logic [N*DW-1:0] nf = '0;
            if (frame_ready && hb > 0) held--;
            if (in_valid && hb < 2) begin
                part.push_back(in_data);
                if (part.size() == N) begin
                    for (int i = 0; i < N; i++) nf[slot(i)*DW +: DW] = part[i];
                    expq.push_back(nf);
                    part.delete();
                    held++;
                end
            end
            m_ovf = (in_valid && hb == 2) ? 1'b1 : ovf_clr ? 1'b0 : m_ovf;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("frame_valid", frame_valid, held > 0);
            chk("overflow", overflow, m_ovf);
            if (frame_valid && frame_ready) begin
                hs++;
                if (expq.size() == 0) chk("frame_pop_empty", 1, 0);
                else chk("frame_data", frame_data, expq.pop_front());
            end
        end
    end

    initial begin
        rst = 0; in_valid = 0; in_data = 0; frame_ready = 0; ovf_clr = 0;
        #3;
        chk("reset_valid", frame_valid, 0);
        chk("reset_ovf", overflow, 0);
        chk("reset_data", frame_data, 0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1;
        @(posedge clk);
        #1;
        // 1: first frame, 1..16
        for (int i = 1; i <= 16; i++) drive(1, DW'(i), 0, 0);
        f = frame_data;
        chk("t1_valid", frame_valid, 1);
        chk("t1_slot0", f[0 +: DW], 1);
        chk("t1_slot15", f[15*DW +: DW], 16);
`ifdef FIR_FRAME_BITREV_EN
        chk("t1_slot8", f[8*DW +: DW], 2);
`else
        chk("t1_slot1", f[1*DW +: DW], 2);
`endif
        repeat (3) drive(0, 0, 1, 0);
        // 2: 40 samples, no consumer
        for (int i = 1; i <= 40; i++) drive(1, DW'(i), 0, 0);
        chk("t2_ovf", overflow, 1);
        repeat (4) drive(0, 0, 1, 0);
        chk("t2_drained", expq.size(), 0);
        drive(0, 0, 0, 1);
        // 3: steady streaming
        h0 = hs;
        for (int i = 0; i < 64; i++) drive(1, DW'(100 + i), 1, 0);
        repeat (3) drive(0, 0, 1, 0);
        chk("t3_frames", hs - h0, 4);
        chk("t3_ovf", overflow, 0);
        // 4: drop coincident with handshake
        for (int i = 0; i < 32; i++) drive(1, DW'($urandom), 0, 0);
        drive(1, 16'hdead, 1, 0);
        chk("t4_ovf", overflow, 1);
        chk("t4_one_full", frame_valid, 1);
        drive(0, 0, 1, 0);
        chk("t4_none_full", frame_valid, 0);
        // 5: overflow clear vs set
        drive(0, 0, 0, 1);
        chk("t5_clr", overflow, 0);
        for (int i = 0; i < 32; i++) drive(1, DW'($urandom), 0, 0);
        drive(1, 16'hbeef, 0, 1);
        chk("t5_set_wins", overflow, 1);
        repeat (3) drive(0, 0, 1, 1);
        // 6: async reset mid-frame
        for (int i = 0; i < 23; i++) drive(1, DW'($urandom_range(1, 65535)), 0, 0);
        in_valid = 0;
        #2 rst = 0;
        #1;
        chk("t6_valid", frame_valid, 0);
        chk("t6_ovf", overflow, 0);
        chk("t6_data", frame_data, 0);
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;
        h0 = hs;
        for (int i = 0; i < 16; i++) drive(1, DW'($urandom), 0, 0);
        repeat (2) drive(0, 0, 1, 0);
        chk("t6_frames", hs - h0, 1);
        // random traffic
        for (int i = 0; i < 400; i++)
            drive($urandom_range(0, 9) < 7, DW'($urandom), $urandom_range(0, 9) < 4, $urandom_range(0, 9) == 0);
        repeat (4) drive(0, 0, 1, 0);
        chk("rand_drained", expq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/fir_frame_buffer.md
Name: fir_frame_buffer

Overview:
- Downstream stage of the FIR filter. Collects the serial 16-bit FIR output samples into N-sample frames for the block-based consumer (FFT input stage).
- Ping-pong buffered: two N-word banks. One bank fills while the other is held for the consumer.
- Consumer takes a whole frame in parallel through a valid/ready handshake.

Parameters:
- DW, 16, sample width in bits; matches the FIR output width.
- N, 16, samples per frame; must be a power of 2.
- LOG2N, 4, log2(N); width of the write pointer.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low; rst=0 clears all state immediately.
- in_valid  input  1  sample strobe; each cycle it is high carries one new FIR sample (driven by the FIR output-valid, qualified per new sample).
- in_data  input  DW  FIR sample, two's complement.
- frame_valid  output  1  a full frame is presented on frame_data.
- frame_ready  input  1  consumer accepts the frame this cycle.
- frame_data  output  N*DW  frame; sample k at bits [k*DW +: DW]; k=0 is the oldest sample.
- overflow  output  1  sticky flag; set when an input sample is dropped.
- ovf_clr  input  1  synchronous clear of overflow.

Behaviour:
- State:
  - mem[2][N] of DW bits.
  - wbank (1b): bank being filled.
  - wptr (LOG2N b): next write slot.
  - rbank (1b): bank being presented.
  - full[1:0]: per-bank full flags.
  - overflow register.
- Reset (rst=0, asynchronous):
  - wbank=0, rbank=0, wptr=0, full=2'b00, overflow=0.
  - Hence frame_valid=0. mem is cleared to 0, so frame_data reads 0.
- Accept rule: an in_valid cycle is accepted when full[wbank]==0, evaluated on registered state.
  - Accepted sample: mem[wbank][wptr] <= in_data; wptr <= wptr+1.
  - If wptr==N-1: wptr wraps to 0, full[wbank] <= 1, wbank toggles.
- Drop rule: in_valid with full[wbank]==1 (both banks full).
  - Sample is discarded; wptr and mem are unchanged; overflow <= 1.
  - This holds even if the same cycle's handshake frees that bank; there is no bypass.
- Output:
  - frame_valid = full[rbank].
  - frame_data = mem[rbank], driven directly from registers.
  - frame_data is stable while frame_valid=1 and frame_ready=0, because writes never target a full bank.
- Handshake: when frame_valid && frame_ready at a rising edge, full[rbank] <= 0 and rbank toggles.
  - frame_ready while frame_valid=0 has no effect.
- Latency: frame_valid rises the cycle after the clock edge that accepts the N-th sample of a frame.
- Simultaneous events: completing a fill of bank X and consuming bank Y in the same cycle both take effect. full bits are updated independently per bank.
- Steady streaming (in_valid every cycle, frame_ready held high) never drops samples.
- overflow:
  - ovf_clr=1 clears it.
  - If ovf_clr and a drop occur in the same cycle, set wins (overflow=1).
- Reset mid-frame: partially written samples are lost. The next accepted sample after reset lands at bank 0, slot 0.

Optional Feature:
- Macro: FIR_FRAME_BITREV_EN.
- Defined: write address is bit-reverse(wptr) over LOG2N bits, so frame_data is in bit-reversed order for a radix-2 DIT FFT. Example, N=16: 2nd sample (wptr=1) is stored at slot 8.
- Not defined: natural order; write address = wptr.
- Handshake, full/overflow logic and latency are identical in both builds.

Test Plan:
1. Reset, then 16 in_valid cycles with in_data=1..16 and frame_ready=0.
   - frame_valid=1 one cycle after the 16th sample; slot0=1, slot15=16.
   - Without BITREV: slot1=2. With BITREV: slot8=2.
2. frame_ready=0 throughout, 40 samples.
   - Two frames are held; samples 33..40 are dropped; overflow=1.
   - After one handshake, the consumer sees samples 1..16, then 17..33-free frame 17..32; sample 33 never appears.
3. Continuous in_valid for 64 cycles with frame_ready=1.
   - Exactly 4 frames are handshaked, each with consecutive values; overflow stays 0.
4. Both banks full; in_valid, frame_valid and frame_ready all high in the same cycle.
   - Sample dropped, overflow=1, rbank toggles, full has exactly one bit set.
5. Set overflow, then pulse ovf_clr alone; then pulse ovf_clr together with a drop.
   - overflow=0 after the lone clear; overflow=1 after the combined cycle.
6. Assert rst=0 asynchronously after 7 samples, between clock edges.
   - Outputs go to 0 immediately.
   - After release, 16 new samples produce a frame that contains only post-reset data.
